// File: rtl/lpc_pkg.sv
// lpc_pkg: shared widths, saturation bounds, autocorrelation FSM states and clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lpc_pkg;

    localparam int Q15_W = 16;
    localparam int Q31_W = 32;

    localparam logic signed [Q31_W-1:0] SAT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [Q31_W-1:0] SAT32_MIN = 32'sh8000_0000;

    // NORM is only entered when the lag-normalisation build option is on
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        NORM  = 2'd1,
        DRAIN = 2'd2
    } ac_state_t;

    // Ceiling log2 for sizing counters and index ports
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lpc_cls32.sv
// lpc_cls32: count of leading redundant sign bits of a 32-bit word (0 for a zero word).
// Latency: combinational.
// Backpressure: none.
module lpc_cls32 (
    input  logic [31:0] din,
    output logic [4:0]  cls
);

    logic done;

    // Walk down from bit 30 while bits still match the sign bit
    always_comb begin
        cls  = '0;
        done = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (!done && (din[i] == din[31])) begin
                cls = cls + 5'd1;
            end else begin
                done = 1'b1;
            end
        end
        if (din == '0) begin
            cls = '0;
        end
    end

endmodule

// File: rtl/lpc_autocorr.sv
// lpc_autocorr: accumulates R[0..ORDER] over FRAME_LEN Q15 samples, emits sat32(R >>> SHIFT) per lag.
// Latency: first lag valid 1 cycle after last accept (2 with LPC_AUTOCORR_NORM_EN, which left-normalises lags by R[0]).
// Backpressure: s_ready low for the whole drain; m_data/m_idx/m_last held while m_ready is low.
module lpc_autocorr
    import lpc_pkg::*;
#(
    parameter int ORDER     = 10,
    parameter int FRAME_LEN = 240,
    parameter int DW        = Q15_W,
    parameter int AW        = 40,
    parameter int SHIFT     = 8,
    parameter int IW        = (clog2(ORDER + 1) < 1) ? 1 : clog2(ORDER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic [IW-1:0] m_idx,
    output logic          m_last
);

    localparam int CW = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
    localparam int PW = 2 * DW;

    ac_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] hist     [0:ORDER-1];
    logic signed [AW-1:0] acc      [0:ORDER];
    logic signed [PW-1:0] prod     [0:ORDER];
    logic signed [AW-1:0] prod_ext [0:ORDER];
    logic signed [DW-1:0] x;
    logic signed [AW-1:0] shifted;
    logic signed [31:0]   sat_val;
    logic signed [31:0]   lag_val;
    logic                 accept;
    logic                 last_accept;
    logic                 out_fire;

    assign x           = s_data;
    assign s_ready     = (state == ACCUM);
    assign m_valid     = (state == DRAIN);
    assign accept      = s_valid & s_ready;
    assign last_accept = accept && (cnt == CW'(FRAME_LEN - 1));
    assign out_fire    = m_valid & m_ready;
    assign m_idx       = idx;
    assign m_last      = m_valid && (idx == IW'(ORDER));
    assign m_data      = m_valid ? lag_val : '0;

    // Full-width products of the new sample against itself and each history tap
    always_comb begin
        prod[0] = PW'(x) * PW'(x);
        for (int k = 1; k <= ORDER; k++) begin
            prod[k] = PW'(x) * PW'(hist[k-1]);
        end
        for (int k = 0; k <= ORDER; k++) begin
            prod_ext[k] = {{(AW-PW){prod[k][PW-1]}}, prod[k]};
        end
    end

    // Scale the selected accumulator down and clamp it into a 32-bit word
    always_comb begin
        shifted = acc[idx] >>> SHIFT;
        if (shifted[AW-1:31] == {(AW-31){shifted[31]}}) begin
            sat_val = shifted[31:0];
        end else if (shifted[AW-1]) begin
            sat_val = SAT32_MIN;
        end else begin
            sat_val = SAT32_MAX;
        end
    end

`ifdef LPC_AUTOCORR_NORM_EN
    logic [4:0] cls_out;
    logic [4:0] nsh;

    // idx is 0 during NORM, so sat_val is sat32(R[0]) when nsh is captured
    lpc_cls32 u_cls (
        .din (sat_val),
        .cls (cls_out)
    );

    // Capture the normalisation shift in the single NORM cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nsh <= '0;
        end else if (state == NORM) begin
            nsh <= cls_out;
        end
    end

    assign lag_val = sat_val <<< nsh;
`else
    assign lag_val = sat_val;
`endif

    // Frame FSM: accumulate, optionally normalise, then drain lags in index order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            cnt   <= '0;
            idx   <= '0;
            for (int k = 0; k < ORDER; k++) begin
                hist[k] <= '0;
            end
            for (int k = 0; k <= ORDER; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int k = 0; k <= ORDER; k++) begin
                            acc[k] <= acc[k] + prod_ext[k];
                        end
                        hist[0] <= x;
                        for (int k = 1; k < ORDER; k++) begin
                            hist[k] <= hist[k-1];
                        end
                        if (last_accept) begin
`ifdef LPC_AUTOCORR_NORM_EN
                            state <= NORM;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                NORM: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (m_last) begin
                            // Frame done: wipe everything so the next frame starts clean
                            state <= ACCUM;
                            idx   <= '0;
                            cnt   <= '0;
                            for (int k = 0; k < ORDER; k++) begin
                                hist[k] <= '0;
                            end
                            for (int k = 0; k <= ORDER; k++) begin
                                acc[k] <= '0;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/lpc_autocorr.md
Name: lpc_autocorr

Overview:
- Frame autocorrelation stage of the LPC analysis chain.
- Consumes a stream of Q15 signed samples and accumulates R[0..ORDER] over a fixed-length frame.
- Emits the lags as 32-bit signed words to the downstream fixed-point Levinson-Durbin recursion.
- Sign extension and arithmetic shifts follow the team's Q15-to-Q31 rules.

Parameters:
- ORDER, 10, highest lag computed; ORDER+1 words are emitted per frame.
- FRAME_LEN, 240, samples per frame.
- DW, 16, input sample width (Q15).
- AW, 40, accumulator width. Must satisfy AW >= 2*DW + clog2(FRAME_LEN).
- SHIFT, 8, arithmetic right shift applied to accumulators before output saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  DW  signed Q15 sample.
- m_valid  out  1  output lag valid.
- m_ready  in  1  downstream ready.
- m_data  out  32  signed lag value R[m_idx].
- m_idx  out  clog2(ORDER+1)  lag index.
- m_last  out  1  high with m_idx==ORDER.

Behaviour:
- Reset (async, rst_n low):
  - State ACCUM.
  - s_ready=1, m_valid=0, m_data=0, m_idx=0, m_last=0.
  - Sample counter, ORDER-deep history line and all accumulators cleared.
  - Reset mid-frame or mid-drain discards all partial results; there is no recovery.
- ACCUM state:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) with x=s_data does, for every k in 0..ORDER: acc[k] += x * h[k-1], with h[-1] meaning x itself.
  - Products are full 2*DW signed, sign-extended to AW. One accept per cycle, no bubbles.
  - History shifts x in. History entries are zero at frame start, so lags never reach into the previous frame.
  - The counter increments per accept. The accept with count==FRAME_LEN-1 updates the accumulators and moves to DRAIN at the same edge.
- DRAIN state:
  - s_ready=0.
  - m_valid=1 starting the cycle after the last sample is accepted, i.e. latency 1 cycle.
  - m_data = sat32(acc[m_idx] >>> SHIFT). Saturation bounds are 0x7FFFFFFF and 0x80000000.
  - m_idx steps 0..ORDER, one step per m_valid & m_ready handshake.
  - While m_ready=0, m_data, m_idx and m_last are held stable.
  - After the handshake with m_last=1: the next cycle clears accumulators, history and counter, returns to ACCUM with s_ready=1, and drops m_valid.
- Input is never accepted while draining; there is no frame overlap.
- s_valid toggling mid-frame only stalls accumulation.

Optional Feature:
- Macro: LPC_AUTOCORR_NORM_EN.
- When defined:
  - An extra NORM state of one cycle sits between ACCUM and DRAIN. NORM registers nsh = count of redundant sign bits of sat32(R[0]); nsh=0 if R[0]==0.
  - All emitted lags become sat32(R[k]) <<< nsh.
  - Latency from the last sample to m_valid becomes 2 cycles.
- When undefined: no NORM state and lags are emitted unshifted.

Decomposition:
- Shared package lpc_pkg holds:
  - Q15/Q31 width constants.
  - SAT32 min/max constants.
  - The autocorrelation state enum (ACCUM, NORM, DRAIN).
  - A clog2 helper.
- One sub-module: lpc_cls32, a combinational count of leading redundant sign bits. It is instantiated only under LPC_AUTOCORR_NORM_EN.

Test Plan:
- Constant frame, 240 samples of 16384, m_ready=1 -> R[0]=0x0F000000 (251658240), R[k]=(240-k)*2^20, R[10]=241172480, m_last only on idx 10.
- Alternating +16384/-16384 frame -> R[0]=251658240, R[1]=-250609664, R[2]=249561088.
- SHIFT=6 with 240 samples of -32768 -> R[0]=0x7FFFFFFF (saturated). R[k] saturates while (240-k)*2^24 > 2^31-1.
- Random backpressure on m_ready, plus s_valid gaps -> same values as the unstalled run. Outputs are stable while stalled. s_ready=0 for the whole drain, and the second frame's results are independent of the first.
- Reset pulse at sample 100 and again mid-drain -> outputs return to reset values immediately. The next full frame of 16384 reproduces the first test's values.
- With LPC_AUTOCORR_NORM_EN, constant 16384 frame -> nsh=3, R[0]=0x78000000, R[10]=0x73000000, m_valid 2 cycles after the last accept. All-zero frame -> all lags 0.
